ray_scheduler: RTL
==================

Name: ray_scheduler

Overview:
Per-frame sequencer for the raycasting datapath. It snapshots the player pose at each new video frame and issues one ray request per screen column into the DDA-in FIFO over a valid/ready stream. It then counts column completions returned by the transformation stage. Once every column is complete, it raises a one-cycle buffer-swap pulse to the frame buffer, aligned to the last video pixel.

Parameters:
SCREEN_WIDTH, 320, number of ray columns per frame
COL_W, $clog2(SCREEN_WIDTH), column index width (9)
POSE_W, 16, width of each signed Q8.8 pose component
DROP_W, 8, width of the saturating dropped-frame counter

Ports:
pixel_clk_in  in  1  pixel clock, sole clock
rst_in  in  1  synchronous reset, active-low
new_frame_in  in  1  one-cycle new-frame pulse from video_sig_gen
video_last_pixel_in  in  1  one-cycle last-screen-pixel pulse
pose_in  in  6*POSE_W  {pos_x, pos_y, dir_x, dir_y, plane_x, plane_y} from controller
pose_out  out  6*POSE_W  frame snapshot of pose, stable for the whole frame
ray_tvalid_out  out  1  ray request valid
ray_tready_in  in  1  DDA-in FIFO ready
ray_tdata_out  out  COL_W  column index of the request
ray_tlast_out  out  1  high with the final column (SCREEN_WIDTH-1)
column_done_in  in  1  one pulse per completed column from transformation
swap_out  out  1  one-cycle frame-buffer swap pulse
busy_out  out  1  high in any state except IDLE
frames_dropped_out  out  DROP_W  saturating count of skipped frames
error_out  out  1  sticky flag for a completion overflow
render_cycles_out  out  24  cycles taken by the last render (see Optional Feature)

Behaviour:
- Reset (rst_in==0 at a clock edge): state IDLE; every output 0, including pose_out, counters and error_out. Reset mid-frame aborts immediately; dropping tvalid is legal only under reset.
- States and transitions:
  - IDLE: on new_frame_in, go to LATCH.
  - LATCH: one cycle; pose_out <= pose_in; col <= 0; done_cnt <= 0; go to ISSUE.
  - ISSUE: ray_tvalid_out=1, ray_tdata_out=col, ray_tlast_out=(col==SCREEN_WIDTH-1).
    - On handshake (tvalid & tready): col++.
    - On handshake with tlast: go to WAIT_DONE; tvalid falls the next cycle.
  - WAIT_DONE: when done_cnt==SCREEN_WIDTH, go to SWAP_WAIT.
  - SWAP_WAIT: the first video_last_pixel_in seen in a cycle after entry raises swap_out for exactly 1 cycle; go to IDLE.
- Stream rules:
  - tdata and tlast are held stable while tvalid & !tready.
  - No combinational path from ray_tready_in to ray_tvalid_out.
  - Back-to-back handshakes give 1 column per cycle.
- Latency: the first request (col 0) is valid 2 cycles after the new_frame_in edge (IDLE→LATCH→ISSUE).
- Completion counting:
  - column_done_in is counted in every state except IDLE and LATCH, so completions may overlap issuing.
  - A pulse arriving when done_cnt==SCREEN_WIDTH is ignored and sets error_out, which stays set until reset.
  - Pulses arriving in IDLE also set error_out.
- Dropped frames: new_frame_in in any non-IDLE state increments frames_dropped_out, saturating at 2^DROP_W-1; the state is unaffected.
- Simultaneous events:
  - new_frame_in in the same cycle as the swap_out pulse counts as dropped, because the state is still SWAP_WAIT.
  - A done pulse coinciding with the final handshake is counted.
- Arithmetic: col and done_cnt are unsigned, COL_W+1 bits; pose is passed through with no arithmetic.

Optional Feature:
- Macro: RAY_SCHED_PERF_EN.
- Defined: a 24-bit cycle counter clears in LATCH, increments every cycle in ISSUE and WAIT_DONE, and saturates at 2^24-1. On entry to SWAP_WAIT its value is copied into render_cycles_out, which holds until the next copy.
- Undefined: render_cycles_out is tied to 0 and no counter logic is generated.

Decomposition:
- Package raycast_pkg holds:
  - the SCREEN_WIDTH and POSE_W constants;
  - the pose_t packed struct of six signed POSE_W fields;
  - the sched_state_t enum {IDLE, LATCH, ISSUE, WAIT_DONE, SWAP_WAIT}.
- One sub-module, sched_sat_counter (parameterised width, saturating increment, synchronous clear). It is used for the dropped-frame counter and for the perf counter.

Test Plan:
- Reset then new_frame_in with tready held 1 → tdata runs 0..319 on consecutive cycles starting 2 cycles after the pulse; tlast high only on 319; busy_out=1.
- tready toggled randomly (50%) → every column 0..319 handshakes exactly once, in order, with tdata stable while stalled.
- Only 319 column_done_in pulses sent → state stays WAIT_DONE and no swap_out. Send the 320th, then video_last_pixel_in 5 cycles later → swap_out is high for 1 cycle, then IDLE.
- new_frame_in pulsed 3 times mid-render → frames_dropped_out=3 and the issue sequence is unaffected. Repeat 300 pulses → saturates at 255.
- 321 column_done_in pulses → error_out=1, still set after the next frame completes; cleared only by rst_in=0.
- Reset asserted during ISSUE at col=100 → next cycle all outputs are 0 and state is IDLE; the next frame restarts at col 0. With RAY_SCHED_PERF_EN and tready=1 and dones overlapping issue, render_cycles_out equals the measured ISSUE+WAIT_DONE cycle count.

Source files
------------

// File: rtl/raycast_pkg.sv
// Shared raycasting types and constants: screen geometry, pose layout and the
// scheduler state encoding.
package raycast_pkg;
    localparam int SCREEN_WIDTH = 320;
    localparam int POSE_W       = 16;

    typedef struct packed {
        logic signed [POSE_W-1:0] pos_x;
        logic signed [POSE_W-1:0] pos_y;
        logic signed [POSE_W-1:0] dir_x;
        logic signed [POSE_W-1:0] dir_y;
        logic signed [POSE_W-1:0] plane_x;
        logic signed [POSE_W-1:0] plane_y;
    } pose_t;

    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        ISSUE,
        WAIT_DONE,
        SWAP_WAIT
    } sched_state_t;
endpackage

// File: rtl/sched_sat_counter.sv
// Saturating up-counter with synchronous active-low reset and synchronous clear.
module sched_sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            cnt <= '0;
        end else if (inc && (cnt != {W{1'b1}})) begin
            cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/ray_scheduler.sv
// Per-frame ray sequencer: latches pose, streams one request per column, counts
// completions and swaps buffers on the last pixel. Optional: RAY_SCHED_PERF_EN.
module ray_scheduler #(
    parameter int SCREEN_WIDTH = raycast_pkg::SCREEN_WIDTH,
    parameter int COL_W        = $clog2(SCREEN_WIDTH),
    parameter int POSE_W       = raycast_pkg::POSE_W,
    parameter int DROP_W       = 8
) (
    input  logic                pixel_clk_in,
    input  logic                rst_in,
    input  logic                new_frame_in,
    input  logic                video_last_pixel_in,
    input  logic [6*POSE_W-1:0] pose_in,
    output logic [6*POSE_W-1:0] pose_out,
    output logic                ray_tvalid_out,
    input  logic                ray_tready_in,
    output logic [COL_W-1:0]    ray_tdata_out,
    output logic                ray_tlast_out,
    input  logic                column_done_in,
    output logic                swap_out,
    output logic                busy_out,
    output logic [DROP_W-1:0]   frames_dropped_out,
    output logic                error_out,
    output logic [23:0]         render_cycles_out
);
    import raycast_pkg::*;

    localparam logic [COL_W:0] LAST_COL = (COL_W+1)'(SCREEN_WIDTH - 1);
    localparam logic [COL_W:0] FULL     = (COL_W+1)'(SCREEN_WIDTH);

    sched_state_t        state_q, state_d;
    logic [COL_W:0]      col_q;
    logic [COL_W:0]      done_cnt_q;
    logic [6*POSE_W-1:0] pose_q;
    logic                error_q;
    logic                counting;
    logic                in_issue;

    assign in_issue = (state_q == ISSUE);
    // Completions may overlap issuing, so counting spans everything past LATCH.
    assign counting = (state_q == ISSUE) || (state_q == WAIT_DONE) || (state_q == SWAP_WAIT);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (new_frame_in) state_d = LATCH;
            LATCH:     state_d = ISSUE;
            ISSUE:     if (ray_tready_in && (col_q == LAST_COL)) state_d = WAIT_DONE;
            WAIT_DONE: if (done_cnt_q == FULL) state_d = SWAP_WAIT;
            SWAP_WAIT: if (video_last_pixel_in) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_ff @(posedge pixel_clk_in) begin
        if (!rst_in) begin
            state_q    <= IDLE;
            col_q      <= '0;
            done_cnt_q <= '0;
            pose_q     <= '0;
            error_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                LATCH: begin
                    pose_q     <= pose_in;
                    col_q      <= '0;
                    done_cnt_q <= '0;
                end
                ISSUE:   if (ray_tready_in) col_q <= col_q + 1'b1;
                default: ;
            endcase
            if (column_done_in) begin
                if ((state_q == IDLE) || (counting && (done_cnt_q == FULL))) begin
                    error_q <= 1'b1;
                end else if (counting) begin
                    done_cnt_q <= done_cnt_q + 1'b1;
                end
            end
        end
    end

    // Valid comes from registered state only: no path from tready.
    assign ray_tvalid_out = in_issue;
    assign ray_tdata_out  = in_issue ? col_q[COL_W-1:0] : '0;
    assign ray_tlast_out  = in_issue && (col_q == LAST_COL);
    assign swap_out       = (state_q == SWAP_WAIT) && video_last_pixel_in;
    assign busy_out       = (state_q != IDLE);
    assign pose_out       = pose_q;
    assign error_out      = error_q;

    sched_sat_counter #(.W(DROP_W)) u_drop_cnt (
        .clk   (pixel_clk_in),
        .rst_n (rst_in),
        .clr   (1'b0),
        .inc   (new_frame_in && (state_q != IDLE)),
        .cnt   (frames_dropped_out)
    );

`ifdef RAY_SCHED_PERF_EN
    logic [23:0] perf_cnt;
    logic [23:0] render_q;

    sched_sat_counter #(.W(24)) u_perf_cnt (
        .clk   (pixel_clk_in),
        .rst_n (rst_in),
        .clr   (state_q == LATCH),
        .inc   ((state_q == ISSUE) || (state_q == WAIT_DONE)),
        .cnt   (perf_cnt)
    );

    // Capture the post-increment value so the final WAIT_DONE cycle is included.
    always_ff @(posedge pixel_clk_in) begin
        if (!rst_in) begin
            render_q <= '0;
        end else if ((state_q == WAIT_DONE) && (state_d == SWAP_WAIT)) begin
            render_q <= (perf_cnt == 24'hFF_FFFF) ? perf_cnt : perf_cnt + 1'b1;
        end
    end

    assign render_cycles_out = render_q;
`else
    assign render_cycles_out = '0;
`endif
endmodule
